// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU VRAM byte writes and drains them in FIFO
// order only while the video timing reports a writable window.
module vram_write_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 12,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_data,
  input  logic              writable,
  output logic              vram_we,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + 8;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  // Status, handshake and head presentation; head is zeroed while empty so
  // stale storage never reaches the VRAM bus.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    pop     = writable && !empty;
    push    = cpu_we && (!full || pop);
    vram_we = pop;
    head    = mem[rd_ptr];
    address = empty ? '0 : head[ENT_W-1:8];
    data    = empty ? '0 : head[7:0];
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= {cpu_address, cpu_data};
    end
  end

  // Pointers, occupancy and sticky overflow; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (cpu_we && full && !pop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// Self-checking bench for vram_write_queue: directed scenarios plus a random
// phase, compared every cycle against a queue-based reference model.
module tb_vram_write_queue;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [7:0]        cpu_data = '0;
  logic              writable = 1'b0;
  logic              overflow_clr = 1'b0;
  logic              vram_we;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  vram_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .writable(writable), .vram_we(vram_we),
    .address(address), .data(data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } ent_t;

  ent_t mq[$];
  ent_t drained[$];
  ent_t exp_list[$];
  logic m_ovf = 1'b0;
  int   we_cycles = 0;
  int   checks = 0;
  int   failures = 0;

  // One comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model; log drained entries.
  task automatic check_outputs(input string ph);
    logic              e_we;
    logic [ADDR_W-1:0] e_a;
    logic [7:0]        e_d;
    e_we = writable && (mq.size() != 0);
    e_a  = (mq.size() != 0) ? mq[0].a : '0;
    e_d  = (mq.size() != 0) ? mq[0].d : '0;
    chk({ph, ".vram_we"}, 32'(vram_we), 32'(e_we));
    chk({ph, ".address"}, 32'(address), 32'(e_a));
    chk({ph, ".data"}, 32'(data), 32'(e_d));
    chk({ph, ".count"}, 32'(count), 32'(mq.size()));
    chk({ph, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({ph, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({ph, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({ph, ".count_le_depth"}, 32'(count <= CNT_W'(DEPTH)), 32'd1);
    if (vram_we === 1'b1) begin
      drained.push_back('{a: address, d: data});
      we_cycles++;
    end
  endtask

  // Reference behaviour on a rising edge, from the queue's rules.
  task automatic model_edge();
    bit pop_m;
    bit push_m;
    bit full_m;
    full_m = (mq.size() == DEPTH);
    pop_m  = writable && (mq.size() != 0);
    push_m = cpu_we && (!full_m || pop_m);
    if (cpu_we && full_m && !pop_m) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back('{a: cpu_address, d: cpu_data});
  endtask

  // One clock: drive, check at negedge, advance model at posedge.
  task automatic cycle(input string ph, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [7:0] d, input logic wr, input logic clr);
    cpu_we = we; cpu_address = a; cpu_data = d; writable = wr; overflow_clr = clr;
    @(negedge clk);
    check_outputs(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare_drain(input string ph);
    chk({ph, ".drain_len"}, 32'(drained.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < drained.size(); i++)
      chk($sformatf("%s.entry%0d", ph, i), 32'(drained[i]), 32'(exp_list[i]));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; cpu_we = 1'b0; overflow_clr = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    ent_t e;

    // Reset then idle with writable high.
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("t1", 0, '0, '0, 1, 0);
    cycle("t1", 0, '0, '0, 1, 0);

    // Three writes buffered, then drained in order.
    exp_list.delete();
    exp_list.push_back('{a: 12'h3C0, d: 8'h1B});
    exp_list.push_back('{a: 12'h000, d: 8'h05});
    exp_list.push_back('{a: 12'h3C0, d: 8'h33});
    foreach (exp_list[i]) cycle("t2p", 1, exp_list[i].a, exp_list[i].d, 0, 0);
    drained.delete(); we_cycles = 0;
    for (int i = 0; i < 6; i++) cycle("t2d", 0, '0, '0, 1, 0);
    chk("t2.we_cycles", 32'(we_cycles), 32'd3);
    compare_drain("t2");

    // Seventeen writes into sixteen entries: last one dropped.
    exp_list.delete();
    for (int i = 0; i < 17; i++) begin
      e = ent_t'($urandom);
      if (i < 16) exp_list.push_back(e);
      cycle("t3p", 1, e.a, e.d, 0, 0);
    end
    cycle("t3o", 0, '0, '0, 0, 0);
    chk("t3.overflow_set", 32'(overflow), 32'd1);
    chk("t3.count_full", 32'(count), 32'(DEPTH));
    cycle("t3c", 0, '0, '0, 0, 1);
    cycle("t3c", 0, '0, '0, 0, 0);
    chk("t3.overflow_clr", 32'(overflow), 32'd0);
    drained.delete(); we_cycles = 0;
    for (int i = 0; i < 18; i++) cycle("t3d", 0, '0, '0, 1, 0);
    compare_drain("t3");

    // Full with simultaneous push and pop.
    exp_list.delete();
    for (int i = 0; i < 16; i++) begin
      e = ent_t'($urandom);
      exp_list.push_back(e);
      cycle("t4p", 1, e.a, e.d, 0, 0);
    end
    e = '{a: 12'hABC, d: 8'h5A};
    exp_list.push_back(e);
    drained.delete(); we_cycles = 0;
    cycle("t4s", 1, e.a, e.d, 1, 0);
    cycle("t4s", 0, '0, '0, 0, 0);
    chk("t4.count_stays", 32'(count), 32'(DEPTH));
    chk("t4.no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 18; i++) cycle("t4d", 0, '0, '0, 1, 0);
    compare_drain("t4");

    // Pointer wrap with writable gap.
    do_reset();
    for (int i = 0; i < 12; i++) cycle("t5a", 1, 12'(i), 8'(i), 0, 0);
    for (int i = 0; i < 12; i++) cycle("t5a", 0, '0, '0, 1, 0);
    exp_list.delete();
    for (int i = 0; i < 10; i++) begin
      e = ent_t'($urandom);
      exp_list.push_back(e);
      cycle("t5p", 1, e.a, e.d, 0, 0);
    end
    drained.delete(); we_cycles = 0;
    for (int i = 0; i < 4; i++) cycle("t5d1", 0, '0, '0, 1, 0);
    chk("t5.first_burst", 32'(we_cycles), 32'd4);
    we_cycles = 0;
    for (int i = 0; i < 20; i++) cycle("t5gap", 0, '0, '0, 0, 0);
    chk("t5.gap_quiet", 32'(we_cycles), 32'd0);
    for (int i = 0; i < 8; i++) cycle("t5d2", 0, '0, '0, 1, 0);
    chk("t5.second_burst", 32'(we_cycles), 32'd6);
    compare_drain("t5");

    // Random traffic with bursty writable.
    for (int i = 0; i < 400; i++) begin
      e = ent_t'($urandom);
      cycle("rnd", ($urandom_range(9) < 7), e.a, e.d,
            (i < 200) ? ($urandom_range(9) < 2) : ($urandom_range(9) < 6),
            ($urandom_range(19) == 0));
    end

    // Reset asserted mid-drain.
    do_reset();
    for (int i = 0; i < 7; i++) cycle("t6p", 1, 12'(i + 100), 8'(i), 0, 0);
    cycle("t6d", 0, '0, '0, 1, 0);
    cycle("t6d", 0, '0, '0, 1, 0);
    chk("t6.count5", 32'(count), 32'd5);
    chk("t6.draining", 32'(vram_we), 32'd1);
    rst = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0;
    chk("t6.async_we", 32'(vram_we), 32'd0);
    chk("t6.async_empty", 32'(empty), 32'd1);
    chk("t6.async_addr", 32'(address), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_list.delete();
    exp_list.push_back('{a: 12'h155, d: 8'hC3});
    drained.delete(); we_cycles = 0;
    cycle("t6n", 1, 12'h155, 8'hC3, 1, 0);
    for (int i = 0; i < 3; i++) cycle("t6n", 0, '0, '0, 1, 0);
    chk("t6.we_cycles", 32'(we_cycles), 32'd1);
    compare_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Buffers CPU-side VRAM writes (PMB/NTBL byte writes) that arrive at arbitrary times.
- Drains them into the background/sprite memories only while the video timing asserts `writable`, so VRAM is never modified mid-scanline.
- Sits directly upstream of the background stage: drives its `data` and `address` ports plus a write strobe.
- Depth-parameterised synchronous FIFO with first-word-fall-through head, occupancy count and sticky overflow flag.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 12, VRAM byte address width; matches the background address port.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  pixel clock, 12.5875 MHz.
- rst  in  1  asynchronous, active-low reset.
- cpu_we  in  1  write request from the CPU bus, one byte per cycle high.
- cpu_address  in  ADDR_W  CPU write address.
- cpu_data  in  8  CPU write data.
- writable  in  1  video timing window where VRAM may be written.
- vram_we  out  1  write strobe to VRAM stages.
- address  out  ADDR_W  VRAM write address (head entry).
- data  out  8  VRAM write data (head entry).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CNT_W  entries currently queued.
- overflow  out  1  sticky: a write was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (rst low, async): rd_ptr = wr_ptr = 0, count = 0, overflow = 0.
  - Outputs during reset: empty = 1, full = 0, vram_we = 0, address = 0, data = 0.
  - Storage contents are not reset.
  - Reset mid-drain discards all queued entries; vram_we drops immediately, asynchronously.
- push = cpu_we && (!full || pop).
  - A write arriving while full is accepted if a pop happens in the same cycle.
- pop = writable && !empty.
- vram_we = pop, combinational from writable and registered count.
  - vram_we never asserts while writable is low.
  - vram_we deasserts in the same cycle writable falls.
- address/data: show the head entry (mem[rd_ptr]) whenever !empty; forced to 0 when empty.
- Latency: a push at edge N is visible at the head and eligible to drain from cycle N+1. No same-cycle bypass.
- Drain rate: one entry per cycle while writable; order is strictly FIFO, including repeated writes to the same address.
- Pointer updates on each clk rising edge:
  - push: mem[wr_ptr] <= {cpu_address, cpu_data}; wr_ptr wraps at DEPTH.
  - pop: rd_ptr increments, wrapping at DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged when both or neither.
- Overflow:
  - Set on cpu_we && full && !pop; the dropped write does not alter storage or pointers.
  - overflow_clr clears it on the next edge.
  - Simultaneous set and clear: set wins.
- Empty: a push and no pop in the same cycle gives count 1 next cycle. Pop is impossible when empty.
- Writable toggling: draining resumes from the same head entry; no entry is lost or duplicated.
- Counters never exceed DEPTH or go below 0. The bench must check this as an assertion.

Test Plan:
- Reset then idle, writable = 1 → empty = 1, vram_we = 0, address = 0, data = 0, count = 0.
- writable = 0; push 3 writes (0x3C0/0x1B, 0x000/0x05, 0x3C0/0x33); raise writable → vram_we high exactly 3 cycles, with address/data 0x3C0/0x1B, 0x000/0x05, 0x3C0/0x33 in order; then empty = 1.
- writable = 0; push 17 writes at DEPTH 16 → full = 1 after the 16th; the 17th is dropped with overflow = 1, count = 16. Pulse overflow_clr → overflow = 0. Drain → the 16 original writes emerge in order.
- Full, writable = 1, cpu_we = 1 in the same cycle → push and pop both occur, count stays 16, overflow stays 0. The new entry emerges last.
- Drain of 10 entries with writable dropping after 4 cycles for 20 cycles → 4 writes, then vram_we = 0 for 20 cycles, then the remaining 6 in order. Pointer wrap is exercised by pre-advancing wr_ptr to 12.
- Assert rst low mid-drain with count = 5 → vram_we = 0 and empty = 1 asynchronously. After release, a single push drains as the first output entry.
